// File: rtl/parity_serial_rx_if.sv
// Interface bundling the serial line and decoded outputs of parity_serial_rx.
// Optional err_cnt signal present when PARITY_SERIAL_RX_ERR_CNT_EN is defined.
interface parity_serial_rx_if #(
    parameter int DATA_W = 4
);
    logic              rx;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
`ifdef PARITY_SERIAL_RX_ERR_CNT_EN
    logic [7:0]        err_cnt;

    modport master (
        input  rx,
        output data_out, data_valid, parity_err, frame_err, busy, err_cnt
    );
    modport slave (
        output rx,
        input  data_out, data_valid, parity_err, frame_err, busy, err_cnt
    );
`else
    modport master (
        input  rx,
        output data_out, data_valid, parity_err, frame_err, busy
    );
    modport slave (
        output rx,
        input  data_out, data_valid, parity_err, frame_err, busy
    );
`endif
endinterface

// File: rtl/parity_serial_rx.sv
// Framed serial receiver (start, DATA_W data LSB first, parity, stop) with parity/frame checks.
// Define PARITY_SERIAL_RX_ERR_CNT_EN to add a saturating 8-bit parity error counter.
module parity_serial_rx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    parity_serial_rx_if.master     io_bus
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BitLast = BW'(DATA_W - 1);
    localparam logic          OddPar  = 1'(ODD_PARITY);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            r_state;
    logic              r_sync1, r_sync2;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic [DATA_W-1:0] r_data;
    logic              r_valid, r_perr, r_ferr, r_busy;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_par_err;
`ifdef PARITY_SERIAL_RX_ERR_CNT_EN
    logic [7:0]        r_err_cnt;
`endif

    if (DATA_W == 1) begin : g_shift_w1
        assign w_shift_nxt = r_sync2;
    end else begin : g_shift_wn
        assign w_shift_nxt = {r_sync2, r_shift[DATA_W-1:1]};
    end

    assign w_par_err = ((^r_shift) ^ r_par) != OddPar;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef PARITY_SERIAL_RX_ERR_CNT_EN
            r_err_cnt <= '0;
`endif
        end else begin
            r_sync1 <= io_bus.rx;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!r_sync2) begin
                        r_state <= StStart;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    // Mid-bit check rejects glitches shorter than half a bit.
                    if (r_cnt == CntHalf) begin
                        r_cnt <= '0;
                        if (!r_sync2) begin
                            r_state <= StData;
                            r_bit   <= '0;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (r_cnt == CntLast) begin
                        r_cnt   <= '0;
                        r_shift <= w_shift_nxt;
                        if (r_bit == BitLast) begin
                            r_state <= StParity;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StParity: begin
                    if (r_cnt == CntLast) begin
                        r_cnt   <= '0;
                        r_par   <= r_sync2;
                        r_state <= StStop;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StStop: begin
                    // Leave on the stop sample so a following start bit is seen promptly.
                    if (r_cnt == CntLast) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_data  <= r_shift;
                        r_perr  <= w_par_err;
                        r_ferr  <= ~r_sync2;
                        r_valid <= 1'b1;
`ifdef PARITY_SERIAL_RX_ERR_CNT_EN
                        if (w_par_err && (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.data_out   = r_data;
    assign io_bus.data_valid = r_valid;
    assign io_bus.parity_err = r_perr;
    assign io_bus.frame_err  = r_ferr;
    assign io_bus.busy       = r_busy;
`ifdef PARITY_SERIAL_RX_ERR_CNT_EN
    assign io_bus.err_cnt    = r_err_cnt;
`endif
endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
Serial receiver and parity checker. It is the receive end of the 4-bit even/odd parity link. It deserialises a framed serial stream on a single line: start bit, DATA_W data bits LSB first, one parity bit, one stop bit. It then checks the parity bit against the selected parity mode and presents the data word with error flags. It sits after the line interface in the receive path, and its output feeds the downstream consumer logic.

Parameters:
- DATA_W, 4, data bits per frame (legal range 1..16).
- CLKS_PER_BIT, 4, clock cycles per serial bit. Must be even and >= 2.
- ODD_PARITY, 0, parity mode. 0 = even (total ones over data+parity even). 1 = odd (total ones odd).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line. Idle high, asynchronous to clk.
- data_out  output  DATA_W  last received data word.
- data_valid  output  1  one-cycle pulse when data_out/flags update.
- parity_err  output  1  parity mismatch on the last frame.
- frame_err  output  1  stop bit sampled 0 on the last frame.
- busy  output  1  high while not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and wins over all other activity.
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE. Both synchroniser flops reset to 1.
- Input synchroniser: rx passes through a 2-flop synchroniser. The FSM sees only the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rxs==0, go to START and clear the bit-clock counter.
- START: at count CLKS_PER_BIT/2-1, sample rxs (mid-bit).
  - rxs==0: go to DATA and reset the counter.
  - rxs==1: glitch. Return to IDLE with no output and no flags.
- DATA: sample every CLKS_PER_BIT clocks. Shift into the shift register LSB first. After DATA_W samples, go to PARITY.
- PARITY: sample after CLKS_PER_BIT clocks, then go to STOP.
- STOP: sample after CLKS_PER_BIT clocks. In that same cycle, go to IDLE; do not wait out the remainder of the stop bit.
- Output update, on the STOP sample edge:
  - data_out <= shift register.
  - parity_err <= (^data ^ parity_bit) != ODD_PARITY.
  - frame_err <= ~stop_bit.
  - data_valid asserted for exactly one cycle.
- Latency: let edge 0 be the first rising edge at which rx is registered 0. data_valid is high in the cycle after edge 2 + CLKS_PER_BIT/2 + (DATA_W+2)*CLKS_PER_BIT. With defaults, that is edge 28.
- Flag holding: data_out, parity_err and frame_err hold until the next data_valid. A frame with frame_err still updates data_out and asserts data_valid.
- Back-to-back frames: a start bit arriving immediately after the stop sample is accepted. IDLE reacts to rxs==0 on the cycle after STOP.
- Line held low (break): a stop bit of 0 gives frame_err=1. The FSM then re-enters START immediately, because rxs is still 0. No lockup.
- Reset mid-frame: abort, all outputs return to reset values, no data_valid. The partial frame is discarded.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: PARITY_SERIAL_RX_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments by 1 on each data_valid with parity_err=1 (next value).
  - Saturates at 255 and does not wrap.
  - Cleared only by rst.
- Undefined: no err_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset check: hold rst high for 3 cycles with rx=1 -> all outputs 0 and busy=0. Assert rst mid-frame at data bit 2 -> outputs 0 next cycle and no data_valid afterwards for that frame.
- Even mode (ODD_PARITY=0), data 4'b0111: send bits 0,1,1,1,0, parity 1, stop 1 -> data_valid pulse at edge 28, data_out=4'b0111, parity_err=0, frame_err=0. Repeat with parity bit 0 -> parity_err=1.
- Odd mode (ODD_PARITY=1), data 4'b1010 with parity 1 -> parity_err=0. Data 4'b0000 with parity 0 -> parity_err=1. Data 4'b1111 with parity 1 -> parity_err=0.
- Glitch rejection: rx low for 1 clock, then high -> busy pulses, returns to IDLE, no data_valid, data_out unchanged.
- Framing and back-to-back: frame 4'b1001 (even, parity 0) with stop bit 0 -> frame_err=1, data_out=4'b1001. Next, send 4'b1101 (parity 1) starting right after the stop sample -> second data_valid with data_out=4'b1101 and both flags 0.
- With PARITY_SERIAL_RX_ERR_CNT_EN defined: 3 bad-parity frames followed by 1 good frame -> err_cnt=3. Force 260 bad frames -> err_cnt=255.
